// File: rtl/otter_pkg.sv
// Shared RV32I core types: ALU function codes, opcodes and the issue record
// passed from the issue stage to the ALU stage.
package otter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_LUI  = 4'b1001,
    ALU_SRA  = 4'b1101
  } alu_fun_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    alu_fun_t        alu_fun;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [4:0]      rd_addr;
    logic            rd_we;
    logic            illegal;
  } alu_issue_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of one RV32I instruction into ALU function and operands.
module alu_op_decode
  import otter_pkg::*;
(
  input  logic [XLEN-1:0] ir_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output alu_issue_t      op_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;
  logic            is_shift;

  assign opcode   = ir_i[6:0];
  assign funct3   = ir_i[14:12];
  assign imm_i    = {{20{ir_i[31]}}, ir_i[31:20]};
  assign imm_s    = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
  assign imm_u    = {ir_i[31:12], 12'b0};
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    op_o         = '0;
    op_o.alu_fun = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        op_o.alu_fun = alu_fun_t'({ir_i[30], funct3});
        op_o.srcA    = rs1_data_i;
        op_o.srcB    = rs2_data_i;
        op_o.rd_we   = 1'b1;
      end
      OPC_OP_IMM: begin
        // ir[30] only selects SRA; for ADDI etc. it is an immediate bit
        op_o.alu_fun = alu_fun_t'({ir_i[30] & (funct3 == 3'b101), funct3});
        op_o.srcA    = rs1_data_i;
        op_o.srcB    = is_shift ? {27'b0, ir_i[24:20]} : imm_i;
        op_o.rd_we   = 1'b1;
      end
      OPC_LUI: begin
        op_o.alu_fun = ALU_LUI;
        op_o.srcB    = imm_u;
        op_o.rd_we   = 1'b1;
      end
      OPC_AUIPC: begin
        op_o.srcA  = pc_i;
        op_o.srcB  = imm_u;
        op_o.rd_we = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        op_o.srcA  = pc_i;
        op_o.srcB  = 32'd4;
        op_o.rd_we = 1'b1;
      end
      OPC_LOAD: begin
        op_o.srcA  = rs1_data_i;
        op_o.srcB  = imm_i;
        op_o.rd_we = 1'b1;
      end
      OPC_STORE: begin
        op_o.srcA = rs1_data_i;
        op_o.srcB = imm_s;
      end
      OPC_BRANCH: begin
        op_o.alu_fun = ALU_SUB;
        op_o.srcA    = rs1_data_i;
        op_o.srcB    = rs2_data_i;
      end
      default: op_o.illegal = 1'b1;
    endcase
    op_o.rd_addr = op_o.rd_we ? ir_i[11:7] : 5'd0;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: decodes into ALU ops and buffers them in a
// 2-entry skid buffer so execute backpressure never reaches decode combinationally.
module alu_issue_stage
  import otter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] ir,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_fun,
  output logic [XLEN-1:0] srcA,
  output logic [XLEN-1:0] srcB,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal
);

  // bit0 = main valid, bit1 = skid valid, so handshake outputs are raw flop bits
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0] state_q, state_d;
  alu_issue_t main_q, main_d;
  alu_issue_t skid_q, skid_d;
  alu_issue_t dec;
  logic       accept, consume;

  alu_op_decode u_dec (
    .ir_i       (ir),
    .pc_i       (pc),
    .rs1_data_i (rs1_data),
    .rs2_data_i (rs2_data),
    .op_o       (dec)
  );

  assign in_ready  = ~state_q[1];
  assign out_valid = state_q[0];
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          main_d = dec;
        end else if (accept) begin
          skid_d  = dec;
          state_d = ST_FULL;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign alu_fun = main_q.alu_fun;
  assign srcA    = main_q.srcA;
  assign srcB    = main_q.srcB;
  assign rd_addr = main_q.rd_addr;
  assign rd_we   = main_q.rd_we;
  assign illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: accepted ops are modelled and queued,
// a monitor checks occupancy and every presented op against the queue head.
module tb_alu_issue_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] ir = '0, pc = '0, rs1_data = '0, rs2_data = '0;
  logic        in_ready, out_valid, rd_we, illegal;
  logic [3:0]  alu_fun;
  logic [31:0] srcA, srcB;
  logic [4:0]  rd_addr;

  alu_issue_stage #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ir(ir), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_fun(alu_fun), .srcA(srcA), .srcB(srcB),
    .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  fun;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        we, ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rst_last = 1'b1;

  function automatic exp_t ref_model(logic [31:0] i, logic [31:0] p,
                                     logic [31:0] r1, logic [31:0] r2);
    exp_t        e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_u;
    opc   = i[6:0];
    f3    = i[14:12];
    imm_i = 32'($signed(i) >>> 20);
    imm_s = (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
    imm_u = i & 32'hFFFFF000;
    e.fun = 4'd0; e.a = 0; e.b = 0; e.we = 0; e.ill = 0;
    case (opc)
      7'h33: begin e.fun = {i[30], f3}; e.a = r1; e.b = r2; e.we = 1; end
      7'h13: begin
        e.fun = {i[30] && (f3 == 3'd5), f3};
        e.a   = r1;
        e.b   = (f3 == 3'd1 || f3 == 3'd5) ? 32'(i[24:20]) : imm_i;
        e.we  = 1;
      end
      7'h37: begin e.fun = 4'd9; e.b = imm_u; e.we = 1; end
      7'h17: begin e.a = p; e.b = imm_u; e.we = 1; end
      7'h6F, 7'h67: begin e.a = p; e.b = 4; e.we = 1; end
      7'h03: begin e.a = r1; e.b = imm_i; e.we = 1; end
      7'h23: begin e.a = r1; e.b = imm_s; end
      7'h63: begin e.fun = 4'd8; e.a = r1; e.b = r2; end
      default: e.ill = 1;
    endcase
    e.rd = e.we ? i[11:7] : 5'd0;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Output-side monitor: occupancy, head-of-queue compare, pop on consume
  always @(negedge CLK) begin
    if (rst_last) begin
      chk("rst_alu_fun", 32'(alu_fun), 32'd0);
      chk("rst_srcA", srcA, 32'd0);
      chk("rst_srcB", srcB, 32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      chk("rst_rd_we", 32'(rd_we), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
    end
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (out_valid && q.size() > 0) begin
      chk("alu_fun", 32'(alu_fun), 32'(q[0].fun));
      chk("srcA", srcA, q[0].a);
      chk("srcB", srcB, q[0].b);
      chk("rd_addr", 32'(rd_addr), 32'(q[0].rd));
      chk("rd_we", 32'(rd_we), 32'(q[0].we));
      chk("illegal", 32'(illegal), 32'(q[0].ill));
      if (out_ready) void'(q.pop_front());
    end
    if (flush || RST) q.delete();
    rst_last = RST;
  end

  // Input-side monitor runs after the output monitor so flush clears first
  always @(negedge CLK) begin
    #1;
    if (in_valid && in_ready && !flush && !RST)
      q.push_back(ref_model(ir, pc, rs1_data, rs2_data));
  end

  task automatic drive(bit v, logic [31:0] i, logic [31:0] r1, logic [31:0] r2,
                       bit ordy, bit fl, bit rst);
    @(posedge CLK);
    #1;
    in_valid  = v;
    ir        = i;
    pc        = $urandom & 32'hFFFFFFFC;
    rs1_data  = r1;
    rs2_data  = r2;
    out_ready = ordy;
    flush     = fl;
    RST       = rst;
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SRAI = 32'h40335293;
  localparam logic [31:0] I_LUI  = 32'h123453B7;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  logic [6:0] opc_tbl [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F,
                               7'h67, 7'h03, 7'h23, 7'h63, 7'h7F};

  initial begin
    logic [31:0] r;
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    // directed ops with execute always ready
    drive(1, I_ADD, 32'd5, 32'd7, 1, 0, 0);
    drive(1, I_SRAI, 32'h80000000, $urandom, 1, 0, 0);
    drive(1, I_LUI, $urandom, $urandom, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    // backpressure fills the buffer, then drains in order
    drive(1, I_ADD, 32'd11, 32'd22, 0, 0, 0);
    drive(1, I_LUI, 32'd1, 32'd2, 0, 0, 0);
    drive(1, I_SRAI, 32'd3, 32'd4, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    // flush from FULL with a same-cycle input
    drive(1, I_ADD, 32'd9, 32'd8, 0, 0, 0);
    drive(1, I_LUI, 32'd7, 32'd6, 0, 0, 0);
    drive(1, I_SRAI, 32'd5, 32'd4, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    // illegal op in order, then reset mid-stream
    drive(1, I_ILL, 32'd1, 32'd1, 1, 0, 0);
    drive(1, I_ADD, 32'd2, 32'd3, 1, 0, 0);
    drive(1, I_LUI, 32'd4, 32'd5, 0, 0, 0);
    drive(1, I_SRAI, 32'd6, 32'd7, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      drive(($urandom % 4) != 0,
            {r[31:7], opc_tbl[$urandom % 10]},
            $urandom, $urandom,
            ($urandom % 3) != 0,
            ($urandom % 32) == 0,
            ($urandom % 250) == 0);
    end
    for (int n = 0; n < 4; n++) drive(0, 0, 0, 0, 1, 0, 0);
    @(negedge CLK);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue stage for the pipelined RV32I core: the producer side of the ALU's `alu_fun`/`srcA`/`srcB` interface. It decodes the instruction word into the 4-bit ALU function code and selects both operands from register data, PC and immediates. The results are registered into a 2-entry skid buffer with valid/ready handshakes on both sides, so execute-stage backpressure never loses an instruction, and decode sees only a registered `in_ready`.

## Interface
Parameters:
- `XLEN`, 32, datapath width (only 32 supported)

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1  clock, all state on rising edge
- `RST`  in  1  synchronous active-high reset
- `flush`  in  1  drop all buffered entries (branch mispredict/trap)
- `in_valid`  in  1  decode offers an instruction
- `in_ready`  out  1  stage can accept; `= !full`, registered-derived
- `ir`  in  32  instruction word
- `pc`  in  32  instruction address
- `rs1_data`  in  32  forwarded rs1 value
- `rs2_data`  in  32  forwarded rs2 value
- `out_valid`  out  1  issued op available to execute
- `out_ready`  in  1  execute consumes op
- `alu_fun`  out  4  ALU function code
- `srcA`  out  32  ALU operand A
- `srcB`  out  32  ALU operand B
- `rd_addr`  out  5  destination register
- `rd_we`  out  1  writeback enable
- `illegal`  out  1  unsupported opcode

## Operation
- Function codes: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, LUI 1001, SRA 1101.
- OP (0110011): `alu_fun={ir[30],ir[14:12]}`, A=rs1, B=rs2, rd_we=1.
- OP-IMM (0010011): `alu_fun={ir[30]&(funct3==101),funct3}`, A=rs1, B=sign-extended I-imm; for shifts B=`{27'b0,ir[24:20]}`. rd_we=1.
- LUI (0110111): alu_fun=1001, A=0, B=`{ir[31:12],12'b0}`, rd_we=1.
- AUIPC (0010111): ADD, A=pc, B=U-imm, rd_we=1.
- JAL (1101111)/JALR (1100111): ADD, A=pc, B=4 (link value), rd_we=1.
- LOAD (0000011): ADD, A=rs1, B=I-imm, rd_we=1. STORE (0100011): ADD, A=rs1, B=S-imm, rd_we=0.
- BRANCH (1100011): SUB, A=rs1, B=rs2, rd_we=0.
- Any other opcode: illegal=1, ADD, A=B=0, rd_we=0; still issued in order.
- rd_addr=ir[11:7] always; forced 0 when rd_we=0.
- Buffer states: EMPTY (out_valid=0), ONE (main reg valid), FULL (main+skid valid, in_ready=0).
- EMPTY + accept -> ONE. ONE + accept + no consume -> FULL (input to skid). ONE + consume + no accept -> EMPTY. ONE + accept + consume -> ONE (main reloads). FULL + consume -> ONE (skid moves to main). FULL never accepts.
- flush: next state EMPTY regardless of in/out handshakes; a same-cycle input is discarded; a same-cycle consume still counts for execute.
- Order strictly FIFO; outputs held stable while `out_valid && !out_ready`.

## Timing
- Reset: out_valid=0, state EMPTY, alu_fun=0000, srcA=srcB=0, rd_addr=0, rd_we=0, illegal=0; in_ready=1 from the first edge with RST high. RST overrides flush and handshakes.
- Latency: accept in cycle N -> out_valid in N+1 when buffer empty or consumed in N.
- Throughput one op/cycle with out_ready held high.
- in_ready depends only on state, with no combinational path from out_ready.
- Decode is combinational on the input side; all outputs come straight from flops.

## Structure
- Shared package `otter_pkg`: `alu_fun_t` enum (codes above), opcode constants, and the `alu_issue_t` struct {alu_fun, srcA, srcB, rd_addr, rd_we, illegal}, also used by the ALU stage.
- One combinational sub-module `alu_op_decode` (ir, pc, rs1_data, rs2_data -> `alu_issue_t`); top holds the skid buffer and control.

## Test plan
- `add x3,x1,x2` (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_fun=0000, srcA=5, srcB=7, rd_addr=3, rd_we=1.
- `srai x5,x6,3` (0x40335293), rs1=0x80000000 -> alu_fun=1101, srcB=3, rd_addr=5.
- `lui x7,0x12345` (0x123453B7) -> alu_fun=1001, srcA=0, srcB=0x12345000.
- out_ready=0 while issuing add then lui back-to-back -> FULL, in_ready=0 the following cycle; out_ready=1 -> add then lui, in order, one per cycle; in_ready returns to 1.
- From FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, input discarded.
- ir=0x0000007F -> illegal=1, rd_we=0, rd_addr=0, issued in order; RST mid-stream -> all outputs at reset values next cycle.
